// File: rtl/serial_word_pkg.sv
// Shared defaults and state encoding for the serial word loader.
package serial_word_pkg;

   localparam int unsigned SW_WIDTH = 8;
   localparam int unsigned SW_CNT_W = 4;

   typedef enum logic {IDLE, SHIFT} sl_state_t;

endpackage

// File: rtl/serial_word_if.sv
// Serial input stream plus valid/ready word output of the loader.
interface serial_word_if #(parameter int unsigned WIDTH = 8);

   logic             sin_valid;
   logic             sin_bit;
   logic             sin_first;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             word_ready;

   // master is the loader; slave is the bit source / word consumer side
   modport master (
      input  sin_valid, sin_bit, sin_first, word_ready,
      output word, word_valid
   );

   modport slave (
      output sin_valid, sin_bit, sin_first, word_ready,
      input  word, word_valid
   );

endinterface

// File: rtl/word_hold_reg.sv
// Output word register: valid/ready handshake and sticky overflow on a dropped word.
module word_hold_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             overflow
);

   logic accept_c;
   logic drop_c;

   // A completed word is taken if the slot is empty or being emptied this edge
   assign accept_c = load && (!word_valid || ready);
   assign drop_c   = load && word_valid && !ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word       <= '0;
         word_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (accept_c) begin
            word       <= din;
            word_valid <= 1'b1;
         end else if (word_valid && ready) begin
            word_valid <= 1'b0;
         end

         if (drop_c)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_word_loader.sv
// Collects an MSB-first serial stream into WIDTH-bit words, double-buffered onto a valid/ready port.
module serial_word_loader
   import serial_word_pkg::*;
#(
   parameter int unsigned WIDTH = SW_WIDTH,
   parameter int unsigned CNT_W = SW_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   serial_word_if.master     bus,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic              sync_err,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   sl_state_t        state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             sync_err_nxt;
   logic             done_c;
   logic [WIDTH-1:0] word_c;

   // State, shift register and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         bit_cnt  <= cnt_nxt;
         sync_err <= sync_err_nxt;
      end
   end

   // Next-state: framing on sin_first, completion on the WIDTH-th bit
   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      cnt_nxt      = bit_cnt;
      sync_err_nxt = 1'b0;
      done_c       = 1'b0;
      word_c       = {shreg[WIDTH-2:0], bus.sin_bit};

      if (bus.sin_valid) begin
         case (state)
            IDLE: begin
               if (bus.sin_first) begin
                  shreg_nxt = WIDTH'(bus.sin_bit);
                  cnt_nxt   = CNT_W'(1);
                  state_nxt = SHIFT;
               end else begin
                  sync_err_nxt = 1'b1;
               end
            end
            SHIFT: begin
               if (bus.sin_first) begin
                  sync_err_nxt = 1'b1;
                  shreg_nxt    = WIDTH'(bus.sin_bit);
                  cnt_nxt      = CNT_W'(1);
               end else if (bit_cnt == LAST_BIT) begin
                  done_c    = 1'b1;
                  shreg_nxt = word_c;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  shreg_nxt = word_c;
                  cnt_nxt   = bit_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   word_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk        (clk),
      .rst        (rst),
      .load       (done_c),
      .din        (word_c),
      .ready      (bus.word_ready),
      .clr_ovf    (clr_ovf),
      .word       (bus.word),
      .word_valid (bus.word_valid),
      .overflow   (overflow)
   );

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed self-checking bench for serial_word_loader.
module tb_serial_word_loader;

   logic       clk;
   logic       rst;
   logic [3:0] bit_cnt;
   logic       sync_err;
   logic       overflow;
   logic       clr_ovf;

   int checks;
   int fails;

   serial_word_if #(.WIDTH(8)) bus ();

   serial_word_loader #(.WIDTH(8), .CNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .bit_cnt  (bit_cnt),
      .sync_err (sync_err),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One accepted serial bit; returns 1 time unit after the sampling edge
   task automatic bit_in(input logic b, input logic f);
      @(negedge clk);
      bus.sin_valid = 1'b1;
      bus.sin_bit   = b;
      bus.sin_first = f;
      @(posedge clk);
      #1;
      bus.sin_valid = 1'b0;
      bus.sin_first = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) bit_in(w[i], i == 7);
   endtask

   task automatic idle_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input logic r);
      @(negedge clk);
      bus.word_ready = r;
   endtask

   initial begin
      logic [7:0] w;
      checks = 0;
      fails  = 0;
      rst = 1'b1;
      clr_ovf = 1'b0;
      bus.sin_valid = 1'b0;
      bus.sin_bit = 1'b0;
      bus.sin_first = 1'b0;
      bus.word_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_word", 16'(bus.word), 16'h00);
      chk("rst_valid", 16'(bus.word_valid), 16'h0);
      chk("rst_bit_cnt", 16'(bit_cnt), 16'h0);
      chk("rst_sync_err", 16'(sync_err), 16'h0);
      chk("rst_overflow", 16'(overflow), 16'h0);

      // 1: 10000011 with consumer ready
      set_ready(1'b1);
      w = 8'b1000_0011;
      for (int i = 7; i >= 1; i--) bit_in(w[i], i == 7);
      chk("t1_cnt7", 16'(bit_cnt), 16'h7);
      chk("t1_valid_before", 16'(bus.word_valid), 16'h0);
      bit_in(w[0], 1'b0);
      chk("t1_word", 16'(bus.word), 16'h83);
      chk("t1_valid", 16'(bus.word_valid), 16'h1);
      chk("t1_ones", 16'($countones(bus.word)), 16'd3);
      chk("t1_cnt0", 16'(bit_cnt), 16'h0);
      idle_edge();
      chk("t1_handshake_clears", 16'(bus.word_valid), 16'h0);

      // 2: eight ones with a 3-cycle gap
      for (int i = 0; i < 4; i++) bit_in(1'b1, i == 0);
      for (int i = 0; i < 3; i++) begin
         idle_edge();
         chk("t2_gap_cnt", 16'(bit_cnt), 16'h4);
      end
      for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b0);
      chk("t2_word", 16'(bus.word), 16'hFF);
      chk("t2_valid", 16'(bus.word_valid), 16'h1);
      chk("t2_ones", 16'($countones(bus.word)), 16'd8);
      idle_edge();
      chk("t2_drained", 16'(bus.word_valid), 16'h0);

      // 3: consumer stalled, second word overflows
      set_ready(1'b0);
      send_word(8'hA5);
      chk("t3_word_a5", 16'(bus.word), 16'hA5);
      chk("t3_ovf_before", 16'(overflow), 16'h0);
      send_word(8'h3C);
      chk("t3_word_kept", 16'(bus.word), 16'hA5);
      chk("t3_valid_kept", 16'(bus.word_valid), 16'h1);
      chk("t3_ovf_set", 16'(overflow), 16'h1);
      @(negedge clk);
      clr_ovf = 1'b1;
      @(posedge clk);
      #1;
      clr_ovf = 1'b0;
      chk("t3_ovf_clr", 16'(overflow), 16'h0);
      set_ready(1'b1);
      idle_edge();
      chk("t3_drained", 16'(bus.word_valid), 16'h0);

      // 4: resync after 5 partial bits
      bit_in(1'b1, 1'b1);
      bit_in(1'b1, 1'b0);
      bit_in(1'b0, 1'b0);
      bit_in(1'b1, 1'b0);
      bit_in(1'b0, 1'b0);
      chk("t4_cnt5", 16'(bit_cnt), 16'h5);
      chk("t4_no_err", 16'(sync_err), 16'h0);
      w = 8'h81;
      bit_in(w[7], 1'b1);
      chk("t4_sync_err", 16'(sync_err), 16'h1);
      chk("t4_cnt1", 16'(bit_cnt), 16'h1);
      chk("t4_no_word", 16'(bus.word_valid), 16'h0);
      bit_in(w[6], 1'b0);
      chk("t4_err_once", 16'(sync_err), 16'h0);
      for (int i = 5; i >= 0; i--) bit_in(w[i], 1'b0);
      chk("t4_word", 16'(bus.word), 16'h81);
      chk("t4_valid", 16'(bus.word_valid), 16'h1);
      idle_edge();

      // 5: completion coincides with handshake of held word
      set_ready(1'b0);
      send_word(8'h0F);
      chk("t5_held", 16'(bus.word), 16'h0F);
      w = 8'hF0;
      for (int i = 7; i >= 1; i--) bit_in(w[i], i == 7);
      chk("t5_stable", 16'(bus.word), 16'h0F);
      bus.word_ready = 1'b1;
      bit_in(w[0], 1'b0);
      chk("t5_word", 16'(bus.word), 16'hF0);
      chk("t5_valid", 16'(bus.word_valid), 16'h1);
      chk("t5_ovf", 16'(overflow), 16'h0);

      // 6: asynchronous reset mid-word
      set_ready(1'b0);
      bit_in(1'b1, 1'b1);
      bit_in(1'b0, 1'b0);
      bit_in(1'b1, 1'b0);
      bit_in(1'b1, 1'b0);
      chk("t6_cnt4", 16'(bit_cnt), 16'h4);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_word", 16'(bus.word), 16'h00);
      chk("t6_rst_valid", 16'(bus.word_valid), 16'h0);
      chk("t6_rst_cnt", 16'(bit_cnt), 16'h0);
      chk("t6_rst_ovf", 16'(overflow), 16'h0);
      chk("t6_rst_err", 16'(sync_err), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      bit_in(1'b1, 1'b0);
      chk("t6_sync_err", 16'(sync_err), 16'h1);
      chk("t6_cnt_idle", 16'(bit_cnt), 16'h0);
      idle_edge();
      chk("t6_err_pulse", 16'(sync_err), 16'h0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
